// File: rtl/simprisc_lsu_pkg.sv
// Shared types and constants for the SimpRisc load/store unit.
package simprisc_lsu_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2,
    SizeIll  = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWr,
    StResp
  } lsu_state_e;

  // Wide enough to count a read latency of up to 7 cycles.
  localparam int unsigned LatCntW = 3;

endpackage

// File: rtl/simprisc_lsu_if.sv
// Request/response and data-memory port bundle of the SimpRisc load/store unit.
interface simprisc_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  // The LSU side.
  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wdata, mem_rw
  );

  // The execute stage plus data memory side.
  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wdata, mem_rw
  );
endinterface

// File: rtl/simprisc_lsu_align.sv
// Byte-lane extract/extend for loads and lane merge for read-modify-write stores.
module simprisc_lsu_align
  import simprisc_lsu_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  lsu_size_e   size_i,
  input  logic        sext_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ext_o,
  output logic [31:0] merge_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata_i[{lane_i, 3'b000} +: 8];
    half_v  = rdata_i[{lane_i[1], 4'b0000} +: 16];
    ext_o   = rdata_i;
    merge_o = rdata_i;
    unique case (size_i)
      SizeByte: begin
        ext_o = {{24{sext_i & byte_v[7]}}, byte_v};
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SizeHalf: begin
        ext_o = {{16{sext_i & half_v[15]}}, half_v};
        merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end
endmodule

// File: rtl/simprisc_lsu.sv
// SimpRisc load/store unit: one request at a time against a single-port synchronous memory.
// Byte/half support and the read-modify-write path exist only with SIMPRISC_LSU_SUBWORD_EN.
module simprisc_lsu
  import simprisc_lsu_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          nreset,
  simprisc_lsu_if.slave bus
);
  localparam logic [LatCntW-1:0] RdLatCnt = LatCntW'(RD_LAT);

  lsu_state_e         state_q;
  logic [LatCntW-1:0] cnt_q;
  logic [1:0]         lane_q;
  lsu_size_e          size_q;
  logic               sext_q;
  logic               we_q;
  logic [31:0]        wdata_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic               rsp_err_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               mem_rw_q;

  lsu_size_e   req_size;
  logic        req_err;
  logic [31:0] ext_data;
  logic [31:0] merge_data;

  assign req_size = lsu_size_e'(bus.req_size);

  always_comb begin
    req_err = 1'b1;
    unique case (req_size)
`ifdef SIMPRISC_LSU_SUBWORD_EN
      SizeByte: req_err = 1'b0;
      SizeHalf: req_err = bus.req_addr[0];
`endif
      SizeWord: req_err = |bus.req_addr[1:0];
      default:  req_err = 1'b1;
    endcase
  end

`ifdef SIMPRISC_LSU_SUBWORD_EN
  simprisc_lsu_align u_align (
    .lane_i  (lane_q),
    .size_i  (size_q),
    .sext_i  (sext_q),
    .rdata_i (bus.mem_rdata),
    .wdata_i (wdata_q),
    .ext_o   (ext_data),
    .merge_o (merge_data)
  );
`else
  assign ext_data   = bus.mem_rdata;
  assign merge_data = wdata_q;
  logic unused_subword;
  assign unused_subword = ^{lane_q, size_q, sext_q};
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lane_q      <= '0;
      size_q      <= SizeByte;
      sext_q      <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= 1'b0;
    end else begin
      // Pulsed outputs default low; each state raises what it owns.
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            lane_q      <= bus.req_addr[1:0];
            size_q      <= req_size;
            sext_q      <= bus.req_sext;
            we_q        <= bus.req_we;
            wdata_q     <= bus.req_wdata;
            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
            cnt_q       <= '0;
            if (req_err) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (bus.req_we && (req_size == SizeWord)) begin
              state_q     <= StWr;
              mem_rw_q    <= 1'b1;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state_q <= StRdWait;
            end
          end
        end
        StRdWait: begin
          if (cnt_q == RdLatCnt) begin
            if (we_q) begin
              state_q     <= StWr;
              mem_rw_q    <= 1'b1;
              mem_wdata_q <= merge_data;
            end else begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= ext_data;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWr: begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
        end
        StResp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rw    = mem_rw_q;
endmodule

// File: tb/tb_simprisc_lsu.sv
// Scoreboard bench for simprisc_lsu: directed requests push expected responses and writes,
// a negedge monitor pops and compares whenever the LSU responds or writes memory.
module tb_simprisc_lsu;
  localparam int unsigned RdLat = 1;
`ifdef SIMPRISC_LSU_SUBWORD_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif
  // Contents of word 0x20 after the half store and after the byte store.
  localparam logic [31:0] W20A = SubEn ? 32'hABCD3344 : 32'h11223344;
  localparam logic [31:0] W20B = SubEn ? 32'hABCD5A44 : 32'h11223344;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t mon_rsp;
  wr_t  mon_wr;

  logic        clk = 1'b0;
  logic        nreset;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_arr [64];
  logic [31:0] pipe [RdLat];

  simprisc_lsu_if bus ();

  simprisc_lsu #(.RD_LAT(RdLat)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory with RdLat cycles of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
      mem_arr[4] <= 32'hDEADBEEF;
      mem_arr[8] <= 32'h11223344;
    end else if (bus.mem_rw) begin
      mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    pipe[0] <= mem_arr[bus.mem_addr[7:2]];
    for (int i = 1; i < RdLat; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[RdLat-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got data %h err %b expected none", bus.rsp_data,
                 bus.rsp_err);
      end else begin
        mon_rsp = rsp_q.pop_front();
        check("rsp_cycle", cyc, mon_rsp.cyc);
        check("rsp_data", bus.rsp_data, mon_rsp.data);
        check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, mon_rsp.err});
      end
    end
    if (bus.mem_rw === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL write_unexpected: got addr %h data %h expected none", bus.mem_addr,
                 bus.mem_wdata);
      end else begin
        mon_wr = wr_q.pop_front();
        check("wr_cycle", cyc, mon_wr.cyc);
        check("wr_addr", bus.mem_addr, mon_wr.addr);
        check("wr_data", bus.mem_wdata, mon_wr.data);
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_sext  = sext;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic scramble();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd3;
    bus.req_sext  = 1'b1;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.req_ready === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready %b expected 1", bus.req_ready);
    end
  endtask

  // exp is the load result for loads, or the merged word for sub-word stores.
  task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input bit keep);
    bit          ok;
    bit          err;
    int unsigned acc;
    logic [31:0] al;
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)
          || (!SubEn && size < 2'd2);
    al  = {addr[31:2], 2'b00};
    wait_ready(ok);
    if (!ok) return;
    drive(we, size, sext, addr, wdata);
    acc = cyc + 1;
    if (err) begin
      rsp_q.push_back('{cyc: acc, data: 32'h0, err: 1'b1});
    end else if (!we) begin
      rsp_q.push_back('{cyc: acc + RdLat + 1, data: exp, err: 1'b0});
    end else if (size == 2'd2) begin
      wr_q.push_back('{cyc: acc, addr: al, data: wdata});
      rsp_q.push_back('{cyc: acc + 1, data: 32'h0, err: 1'b0});
    end else begin
      wr_q.push_back('{cyc: acc + RdLat + 1, addr: al, data: exp});
      rsp_q.push_back('{cyc: acc + RdLat + 2, data: 32'h0, err: 1'b0});
    end
    @(negedge clk);
    if (!err) check("mem_addr_c0", bus.mem_addr, al);
    if (!keep) scramble();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    bit ok;
    int n;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_sext  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    nreset        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    check("reset_rsp_data", bus.rsp_data, 32'd0);
    check("reset_mem_rw", {31'b0, bus.mem_rw}, 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata, 32'd0);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80112233, 32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h9999ABCD, 32'hABCD3344, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, W20A, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'hFFFFABCD, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h0000ABCD, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h1234565A, 32'hABCD5A44, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, W20B, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h23, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h02, 32'hCAFEF00D, 32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 32'h00000044, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'h0000005A, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 32'hFFFFFFCD, 1'b0);

    // Reset in cycle 1 of a half store: no write, no response.
    wait_ready(ok);
    if (ok) begin
      drive(1'b1, 2'd1, 1'b0, 32'h22, 32'h00007777);
      if (!SubEn) rsp_q.push_back('{cyc: cyc + 1, data: 32'h0, err: 1'b1});
      @(negedge clk);
      scramble();
      @(negedge clk);
      nreset = 1'b0;
      #1;
      check("abort_mem_rw", {31'b0, bus.mem_rw}, 32'd0);
      check("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("abort_req_ready", {31'b0, bus.req_ready}, 32'd0);
      release_reset();
    end
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, W20B, 1'b0);

    // Reset while a word store drives mem_rw: the strobe must drop at once.
    wait_ready(ok);
    if (ok) begin
      drive(1'b1, 2'd2, 1'b0, 32'h3C, 32'hFEEDFACE);
      @(posedge clk);
      #2;
      scramble();
      nreset = 1'b0;
      #1;
      check("async_mem_rw_drop", {31'b0, bus.mem_rw}, 32'd0);
      release_reset();
    end
    issue(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);

    // Back-to-back word stores with req_valid held high.
    issue(1'b1, 2'd2, 1'b0, 32'h30, 32'hAAAA0001, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h34, 32'hAAAA0002, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h38, 32'hAAAA0003, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, 32'hAAAA0002, 1'b0);

    n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rsp_outstanding", rsp_q.size(), 32'd0);
    check("wr_outstanding", wr_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
